// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through data-cache controller driving the pipeline stall-release `hit`.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_MISS,
        S_FILL,
        S_WR_THRU,
        S_WR_DONE
    } state_t;

    state_t state, state_n;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_arr  [LINES];
    logic [31:0]         data_arr [LINES];
    logic [31:0]         fill_data;

    logic [31:0]           word_addr;
    logic [INDEX_BITS-1:0] cpu_idx, mem_idx;
    logic [TAG_BITS-1:0]   cpu_tag, mem_tag;
    logic                  lookup_hit, read_hit;
    logic                  req_start, req_done;

    assign word_addr  = {cpu_addr[31:2], 2'b00};
    assign cpu_idx    = word_addr[INDEX_BITS+1:2];
    assign cpu_tag    = word_addr[31:INDEX_BITS+2];
    // Fill and write-through use the latched request address, not the live CPU bus.
    assign mem_idx    = mem_addr[INDEX_BITS+1:2];
    assign mem_tag    = mem_addr[31:INDEX_BITS+2];
    assign lookup_hit = valid[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n   = state;
        hit       = 1'b0;
        cpu_rdata = 32'h0;
        read_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_wr) begin
                    state_n = S_WR_THRU;
                end else if (cpu_rd) begin
                    if (lookup_hit) begin
                        hit       = 1'b1;
                        read_hit  = 1'b1;
                        cpu_rdata = data_arr[cpu_idx];
                    end else begin
                        state_n = S_RD_MISS;
                    end
                end else begin
                    hit = 1'b1;
                end
            end
            S_RD_MISS: if (mem_ack) state_n = S_FILL;
            S_FILL:    state_n = S_IDLE;
            S_WR_THRU: if (mem_ack) state_n = S_WR_DONE;
            S_WR_DONE: begin
                hit     = 1'b1;
                state_n = S_IDLE;
            end
            default:   state_n = S_IDLE;
        endcase
    end

    assign req_start = (state == S_IDLE) && (state_n != S_IDLE);
    assign req_done  = ((state == S_RD_MISS) || (state == S_WR_THRU)) && mem_ack;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            valid     <= '0;
        end else begin
            state <= state_n;
            if (req_start) begin
                mem_req   <= 1'b1;
                mem_we    <= (state_n == S_WR_THRU);
                mem_addr  <= word_addr;
                mem_wdata <= cpu_wdata;
            end else if (req_done) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            if (state == S_FILL) valid[mem_idx] <= 1'b1;
        end
    end

    // NOTE: the tag/data arrays carry no reset; clearing valid alone makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if ((state == S_RD_MISS) && mem_ack) fill_data <= mem_rdata;
            if (state == S_FILL) begin
                data_arr[mem_idx] <= fill_data;
                tag_arr[mem_idx]  <= mem_tag;
            end else if ((state == S_WR_THRU) && mem_ack && valid[mem_idx]
                         && (tag_arr[mem_idx] == mem_tag)) begin
                data_arr[mem_idx] <= mem_wdata;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic after_fill;

    // The lookup right after FILL completes the original miss and is not a new hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            after_fill <= 1'b0;
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            after_fill <= (state == S_FILL);
            if (read_hit && !after_fill) hit_count <= hit_count + 32'd1;
            if (req_start && (state_n == S_RD_MISS)) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl; inputs change just after posedge, outputs
// are sampled on the falling edge. Counter checks are built when DCACHE_STATS_EN is defined.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, cpu_rd, cpu_wr, mem_ack;
    logic [31:0] cpu_addr, cpu_wdata, mem_rdata;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata;
    logic        hit, mem_req, mem_we;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dcache_ctrl #(.INDEX_BITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Memory responder: waits (bounded) for mem_req, holds off `waits` cycles, pulses ack.
    // Returns in the cycle after the ack.
    task automatic serve_mem(input logic [31:0] data, input int waits, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            repeat (waits) tick();
            mem_ack   = 1'b1;
            mem_rdata = data;
            tick();
            mem_ack   = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ack = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_rdata = 32'h0;
        tick(); tick();
        settle();
        n_checks++;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL reset_idle_hit got=%0h exp=1", hit); end
        n_checks++;
        if ({mem_req, mem_we} !== 2'b00) begin
            n_fail++; $display("FAIL reset_req_we got=%b exp=00", {mem_req, mem_we});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, cpu_rdata} !== 96'h0) begin
            n_fail++; $display("FAIL reset_buses got=%h %h %h exp=0", mem_addr, mem_wdata, cpu_rdata);
        end
`ifdef DCACHE_STATS_EN
        n_checks++;
        if ({hit_count, miss_count} !== 64'h0) begin
            n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", hit_count, miss_count);
        end
`endif
        cpu_rd = 1'b1; cpu_addr = 32'h40;
        #1;
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_rd_stall got=%0h exp=0", hit); end
    endtask

    task automatic test_read_miss();
        rst_n = 1'b1;
        tick();
        settle();
        n_checks++;
        if ({mem_req, mem_we, hit} !== 3'b100 || mem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL miss_req got req/we/hit=%b addr=%h exp=100 addr=00000040",
                     {mem_req, mem_we, hit}, mem_addr);
        end
        tick(); tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        settle();
        n_checks++;
        if ({mem_req, hit} !== 2'b00) begin
            n_fail++; $display("FAIL miss_fill got req/hit=%b exp=00", {mem_req, hit});
        end
        tick();
        settle();
        n_checks++;
        if (hit !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL miss_done got hit=%0h data=%h exp=1 deadbeef", hit, cpu_rdata);
        end
    endtask

    task automatic test_hits();
        tick();
        settle();
        n_checks++;
        if (hit !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL hit_repeat got hit=%0h data=%h req=%0h exp=1 deadbeef 0",
                               hit, cpu_rdata, mem_req);
        end
        tick();
        cpu_addr = 32'h43;
        settle();
        n_checks++;
        if (hit !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL hit_offset got hit=%0h data=%h req=%0h exp=1 deadbeef 0",
                               hit, cpu_rdata, mem_req);
        end
        tick();
        cpu_rd = 1'b0;
        settle();
        n_checks++;
        if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL idle_rdata got=%h exp=0", cpu_rdata); end
`ifdef DCACHE_STATS_EN
        n_checks++;
        if (hit_count !== 32'd2 || miss_count !== 32'd1) begin
            n_fail++; $display("FAIL counts_after_hits got=%0d/%0d exp=2/1", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_write_thru();
        tick();
        cpu_wr = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h12345678;
        settle();
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL wr_stall got=%0h exp=0", hit); end
        tick();
        settle();
        n_checks++;
        if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678) begin
            n_fail++; $display("FAIL wr_req got req/we=%b addr=%h wdata=%h exp=11 00000040 12345678",
                               {mem_req, mem_we}, mem_addr, mem_wdata);
        end
        tick();
        settle();
        n_checks++;
        if ({mem_req, mem_we, hit} !== 3'b110) begin
            n_fail++; $display("FAIL wr_wait got req/we/hit=%b exp=110", {mem_req, mem_we, hit});
        end
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        settle();
        n_checks++;
        if ({mem_req, mem_we, hit} !== 3'b001) begin
            n_fail++; $display("FAIL wr_done got req/we/hit=%b exp=001", {mem_req, mem_we, hit});
        end
        cpu_wr = 1'b0;
        tick();
        cpu_rd = 1'b1;
        settle();
        n_checks++;
        if (hit !== 1'b1 || cpu_rdata !== 32'h12345678) begin
            n_fail++; $display("FAIL wr_readback got hit=%0h data=%h exp=1 12345678", hit, cpu_rdata);
        end
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic test_eviction();
        bit ok;
        cpu_rd = 1'b1; cpu_addr = 32'h440;
        settle();
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL evict_miss got=%0h exp=0", hit); end
        serve_mem(32'h04400440, 0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL evict_req_timeout got=none exp=mem_req"); end
        tick();
        settle();
        n_checks++;
        if (hit !== 1'b1 || cpu_rdata !== 32'h04400440) begin
            n_fail++; $display("FAIL evict_fill got hit=%0h data=%h exp=1 04400440", hit, cpu_rdata);
        end
        tick();
        cpu_addr = 32'h40;
        settle();
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL evicted_miss got=%0h exp=0", hit); end
        serve_mem(32'h12345678, 2, ok);
        n_checks++;
        if (!ok || mem_addr !== 32'h40) begin
            n_fail++; $display("FAIL evicted_req got ok=%0d addr=%h exp=1 00000040", ok, mem_addr);
        end
        tick();
        settle();
        n_checks++;
        if (hit !== 1'b1 || cpu_rdata !== 32'h12345678) begin
            n_fail++; $display("FAIL evicted_refill got hit=%0h data=%h exp=1 12345678", hit, cpu_rdata);
        end
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic test_no_allocate();
        bit ok;
        cpu_wr = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'hCAFEF00D;
        serve_mem(32'h0, 0, ok);
        settle();
        n_checks++;
        if (!ok || hit !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL noalloc_wr got ok=%0d hit=%0h req=%0h exp=1 1 0", ok, hit, mem_req);
        end
        cpu_wr = 1'b0;
        tick();
        cpu_rd = 1'b1;
        settle();
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL noalloc_rd_miss got=%0h exp=0", hit); end
        tick();
        settle();
        n_checks++;
        if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h80) begin
            n_fail++; $display("FAIL noalloc_reissue got req/we=%b addr=%h exp=10 00000080",
                               {mem_req, mem_we}, mem_addr);
        end
        serve_mem(32'hCAFEF00D, 0, ok);
        tick();
        settle();
        n_checks++;
        if (hit !== 1'b1 || cpu_rdata !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL noalloc_fill got hit=%0h data=%h exp=1 cafef00d", hit, cpu_rdata);
        end
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        cpu_rd = 1'b1; cpu_addr = 32'h840;
        tick();
        settle();
        n_checks++;
        if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req got=%0h exp=1", mem_req); end
        rst_n = 1'b0;
        tick();
        settle();
        n_checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_drop got req=%0h addr=%h exp=0 0", mem_req, mem_addr);
        end
        rst_n = 1'b1; cpu_rd = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
        tick();
        mem_ack = 1'b0;
        settle();
        n_checks++;
        if (mem_req !== 1'b0 || hit !== 1'b1) begin
            n_fail++; $display("FAIL stray_ack got req=%0h hit=%0h exp=0 1", mem_req, hit);
        end
`ifdef DCACHE_STATS_EN
        n_checks++;
        if ({hit_count, miss_count} !== 64'h0) begin
            n_fail++; $display("FAIL mid_reset_counts got=%0d/%0d exp=0/0", hit_count, miss_count);
        end
`endif
        cpu_rd = 1'b1; cpu_addr = 32'h40;
        #1;
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL post_reset_miss got=%0h exp=0", hit); end
        serve_mem(32'h12345678, 1, ok);
        n_checks++;
        if (!ok || mem_addr !== 32'h40) begin
            n_fail++; $display("FAIL post_reset_req got ok=%0d addr=%h exp=1 00000040", ok, mem_addr);
        end
        tick();
        settle();
        n_checks++;
        if (hit !== 1'b1 || cpu_rdata !== 32'h12345678) begin
            n_fail++; $display("FAIL post_reset_fill got hit=%0h data=%h exp=1 12345678", hit, cpu_rdata);
        end
        tick();
        cpu_rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_hits();
        test_write_thru();
        test_eviction();
        test_no_allocate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
